// File: rtl/sdmac_pkg.sv
// Shared definitions for the SDMAC replacement data path.
// Holds the DMA direction encodings, the byte lane numbers and the default
// FIFO depth. It also holds the byte lane select/merge helpers. Lane 0 is the
// most significant byte, so the data packs big-endian.
package sdmac_pkg;

   localparam logic DIR_S2H = 1'b0;  // SCSI-to-host: bytes in, longwords out
   localparam logic DIR_H2S = 1'b1;  // host-to-SCSI: longwords in, bytes out

   localparam logic [1:0] LANE0 = 2'd0;  // bits 31:24
   localparam logic [1:0] LANE1 = 2'd1;  // bits 23:16
   localparam logic [1:0] LANE2 = 2'd2;  // bits 15:8
   localparam logic [1:0] LANE3 = 2'd3;  // bits 7:0

   localparam int unsigned FIFO_DEPTH_LOG2 = 3;

   // Returns byte lane 'lane' of 'word'.
   function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         LANE0:   b = word[31:24];
         LANE1:   b = word[23:16];
         LANE2:   b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

   // Merges byte 'b' into lane 'lane' of 'word'. Writing lane 0 starts a new
   // word, so the lower lanes are cleared. A later flush then commits zeros
   // in the lanes that were never written.
   function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [7:0] b);
      logic [31:0] w;
      w = word;
      case (lane)
         LANE0:   w = {b, 24'h000000};
         LANE1:   w[23:16] = b;
         LANE2:   w[15:8]  = b;
         default: w[7:0]   = b;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/scsi_fifo.sv
// Byte-to-longword packing FIFO between the SCSI controller's 8-bit data port
// and the 32-bit host DMA side.
//
// Ports:
//   clk_i, rst_i        clock; asynchronous active-high reset
//   dir_i               0 = SCSI-to-host, 1 = host-to-SCSI
//   clr_i               synchronous clear of the pointers, count and lane
//   flush_i             (S2H) commits a partial longword
//   byte_we_i/byte_in_i (S2H) byte push
//   byte_re_i           (H2S) byte pop
//   byte_out_o          byte lane bptr of the head entry (fall-through)
//   lw_we_i/lw_in_i     (H2S) longword push
//   lw_re_i             (S2H) longword pop
//   lw_out_o            head entry (fall-through)
//   full_o, empty_o     flags derived from the committed count
//   count_o             committed longwords held
//   bptr_o              S2H: next write lane; H2S: next read lane
//   flushed_o           pulses in the cycle after a flush is accepted
module scsi_fifo
   import sdmac_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  dir_i,
   input  logic                  clr_i,
   input  logic                  flush_i,
   input  logic                  byte_we_i,
   input  logic [7:0]            byte_in_i,
   input  logic                  byte_re_i,
   output logic [7:0]            byte_out_o,
   input  logic                  lw_we_i,
   input  logic [31:0]           lw_in_i,
   input  logic                  lw_re_i,
   output logic [31:0]           lw_out_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic [1:0]            bptr_o,
   output logic                  flushed_o
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam int unsigned CntW  = DEPTH_LOG2 + 1;

   logic [31:0]           mem_q [Depth];
   logic [31:0]           mem_d [Depth];
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic [1:0]            bptr_q, bptr_d;
   logic                  flushed_q, flushed_d;

   logic                  push;  // a longword is committed this cycle
   logic                  pop;   // the head longword retires this cycle
   logic [1:0]            lane_nxt;

   assign full_o     = (count_q == CntW'(Depth));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign bptr_o     = bptr_q;
   assign flushed_o  = flushed_q;
   assign lw_out_o   = mem_q[rptr_q];
   assign byte_out_o = lane_sel(mem_q[rptr_q], bptr_q);

   always_comb begin
      mem_d     = mem_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      bptr_d    = bptr_q;
      flushed_d = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      lane_nxt  = bptr_q;

      if (clr_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         bptr_d  = '0;
      end else begin
         if (dir_i == DIR_S2H) begin
            // Full/empty tests use the pre-cycle count, so a same-cycle pop
            // never makes room for a byte.
            if (byte_we_i && !full_o) begin
               mem_d[wptr_q] = lane_merge(mem_q[wptr_q], bptr_q, byte_in_i);
               lane_nxt      = bptr_q + 2'd1;
               push          = (bptr_q == LANE3);
            end
            // A flush acts on the lane pointer as it stands after the byte
            // written in the same cycle.
            if (flush_i) begin
               flushed_d = 1'b1;
               if (lane_nxt != LANE0 && !full_o) begin
                  push     = 1'b1;
                  lane_nxt = LANE0;
               end
            end
            pop    = lw_re_i && !empty_o;
            bptr_d = lane_nxt;
         end else begin
            if (lw_we_i && !full_o) begin
               mem_d[wptr_q] = lw_in_i;
               push          = 1'b1;
            end
            if (byte_re_i && !empty_o) begin
               bptr_d = bptr_q + 2'd1;
               pop    = (bptr_q == LANE3);
            end
         end

         wptr_d  = wptr_q + DEPTH_LOG2'(push);
         rptr_d  = rptr_q + DEPTH_LOG2'(pop);
         count_d = count_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         bptr_q    <= '0;
         flushed_q <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         bptr_q    <= bptr_d;
         flushed_q <= flushed_d;
      end
   end

endmodule

// File: doc/scsi_fifo.md
# scsi_fifo

Byte-to-longword packing FIFO between the SCSI controller's 8-bit data port and the 32-bit host DMA side of the SDMAC replacement. It sits directly downstream of the register file. The register file's DMA control bit drives DIR, its FIFO-clear and start-DMA strobes drive CLR, and its flush strobe drives FLUSH. Data packs big-endian: the first byte lands in bits 31:24.

## Interface
- DEPTH_LOG2, 3, log2 of longword entries (default 8 entries).
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- DIR  in  1  0 = SCSI-to-host (bytes in, longwords out); 1 = host-to-SCSI (longwords in, bytes out).
- CLR  in  1  synchronous pointer/count clear, one-cycle strobe.
- FLUSH  in  1  DIR=0 only: commit partial longword, one-cycle strobe.
- BYTE_WE  in  1  push BYTE_IN (DIR=0).
- BYTE_IN  in  8  SCSI byte.
- BYTE_RE  in  1  pop one byte (DIR=1).
- BYTE_OUT  out  8  current byte lane of head entry (fall-through).
- LW_WE  in  1  push LW_IN (DIR=1).
- LW_IN  in  32  host longword.
- LW_RE  in  1  pop head longword (DIR=0).
- LW_OUT  out  32  head entry mem[RPTR] (fall-through).
- FULL  out  1  COUNT == 2^DEPTH_LOG2.
- EMPTY  out  1  COUNT == 0.
- COUNT  out  DEPTH_LOG2+1  committed longwords held.
- BPTR  out  2  DIR=0: next write lane; DIR=1: next read lane.
- FLUSHED  out  1  one-cycle pulse, cycle after FLUSH is accepted.

## Operation
- State: mem[], WPTR, RPTR (DEPTH_LOG2 bits, natural wrap), COUNT, BPTR, FLUSHED.
- Priority each cycle: RST > CLR > data operations. CLR zeroes WPTR, RPTR, COUNT and BPTR. Memory contents are kept. FLUSHED is forced to 0.
- DIR=0, BYTE_WE with !FULL:
  - Writes lane BPTR of mem[WPTR]. Lane 0 = bits 31:24, lane 3 = bits 7:0.
  - A lane-0 write also zeroes bits 23:0.
  - BPTR increments. On lane 3, BPTR wraps to 0, WPTR increments and the longword is committed (COUNT+1).
- DIR=0, BYTE_WE while FULL: ignored. The FULL test uses the pre-cycle COUNT, so a same-cycle LW_RE does not unblock it.
- DIR=0, LW_RE with !EMPTY: RPTR+1, COUNT-1. LW_RE while EMPTY is ignored.
- DIR=0, FLUSH:
  - BPTR≠0: commit the partial word, whose unused lanes are already zero. WPTR+1, COUNT+1, BPTR←0.
  - BPTR=0: no data change.
  - FLUSHED pulses in both cases.
  - FLUSH together with BYTE_WE: the byte is written first, then the flush is applied to the result.
- DIR=1, LW_WE with !FULL: mem[WPTR]←LW_IN, WPTR+1, COUNT+1.
- DIR=1, BYTE_RE with !EMPTY:
  - BYTE_OUT = lane BPTR of mem[RPTR]. BPTR increments.
  - On lane 3: BPTR←0, RPTR+1, COUNT-1.
- Simultaneous commit and pop in the same cycle: COUNT unchanged, both pointers advance.
- Operations for the other direction are ignored: LW_WE/BYTE_RE when DIR=0, and BYTE_WE/LW_RE/FLUSH when DIR=1.
- Changing DIR does not clear state. The register file issues CLR with every direction change.

## Timing
- Reset values: WPTR=RPTR=COUNT=BPTR=0, mem all zero, EMPTY=1, FULL=0, FLUSHED=0, LW_OUT=0, BYTE_OUT=0.
- All pointers, COUNT and BPTR are registered. FULL, EMPTY, LW_OUT and BYTE_OUT are combinational from registered state, so they update the cycle after the causing edge.
- Latency, byte in to longword visible: 1 cycle after the 4th byte, or after the FLUSH.
- Throughput: one byte per cycle and one longword per cycle, concurrently.
- Asynchronous RST mid-transfer discards everything, including a partial longword, with no FLUSHED pulse.

## Structure
- Shared package (sdmac_pkg):
  - DIR_S2H=1'b0, DIR_H2S=1'b1.
  - Lane constants LANE0..LANE3.
  - FIFO_DEPTH_LOG2 default.
- No sub-module required. A lane select/merge function in the package is sufficient.

## Test plan
- Reset, then idle -> EMPTY=1, FULL=0, COUNT=0, BPTR=0, LW_OUT=32'h0.
- DIR=0, bytes 11,22,33,44,55 -> after 4th byte COUNT=1, LW_OUT=32'h11223344; BPTR=1. FLUSH -> FLUSHED pulse, COUNT=2; second word 32'h55000000.
- DIR=1, push 9 longwords 32'hA0B0C0D0+n -> FULL after 8th, 9th ignored. 4×BYTE_RE -> A0,B0,C0,D0, then COUNT=7.
- DIR=0, COUNT=3, byte-4 commit and LW_RE in the same cycle -> COUNT stays 3. With FULL, BYTE_WE+LW_RE -> byte dropped, COUNT=7.
- Stream 20 longwords through DIR=0 with interleaved pops -> pointers wrap, every word matches in order.
- CLR with BPTR=2 and COUNT=5 -> next cycle COUNT=0, BPTR=0, EMPTY=1. Async RST mid-stream -> all reset values immediately, FLUSHED=0.
